// File: rtl/obi_arb_pkg.sv
// Shared types for the 2:1 OBI arbiter: response-owner tags, arbiter FSM
// states and the perf counter width.
package obi_arb_pkg;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam int PERF_CNT_W = 32;

  // The master that is not o; used to hand priority over after a grant.
  function automatic owner_e other_owner(owner_e o);
    return (o == OWN_M0) ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/obi_arbiter_2to1_if.sv
// OBI-style req/gnt/rvalid bus. The "master" modport is the side that issues
// requests; the "slave" modport is the side that grants and returns data.
interface obi_arbiter_2to1_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic                  req;
  logic                  gnt;
  logic                  rvalid;
  logic [ADDR_W-1:0]     addr;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/obi_arb_owner_fifo.sv
// Small FIFO of response owners: one entry per granted-but-unanswered
// transaction, so each rvalid is routed back to the master that issued it.
// Simultaneous push and pop keep the count unchanged and preserve order.
module obi_arb_owner_fifo
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  owner_e data_i,
  input  logic   pop_i,
  output owner_e data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  owner_e             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt == CNT_W'(DEPTH));
  assign empty_o = (cnt == '0);
  assign data_o  = mem[rd_ptr];

  // Storage, wrap-around pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= OWN_M0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_i) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_i, pop_i})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/obi_arbiter_2to1.sv
// Two-master to one-slave OBI arbiter. Round-robin on conflict, request is
// locked onto the chosen master while the slave stalls, and the owner of every
// granted request is queued so responses return to their issuer.
// Optional perf counters are built when OBI_ARB_PERF_EN is defined; otherwise
// the counter ports read 0.
module obi_arbiter_2to1
  import obi_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  obi_arbiter_2to1_if.slave     m0,
  obi_arbiter_2to1_if.slave     m1,
  obi_arbiter_2to1_if.master    s,
  output logic                  err_o,
  output logic [PERF_CNT_W-1:0] cnt_gnt0_o,
  output logic [PERF_CNT_W-1:0] cnt_gnt1_o,
  output logic [PERF_CNT_W-1:0] cnt_conf_o
);

  arb_state_e          state_q, state_d;
  owner_e              sel_q, sel_d;
  owner_e              rr_q;
  owner_e              cand;
  logic                cand_vld;
  logic                s_req, push, pop;
  logic                fifo_full, fifo_empty;
  owner_e              head;
  logic                gnt0, gnt1;
  logic [ADDR_W-1:0]   mux_addr;
  logic [DATA_W-1:0]   mux_wdata;

  // Pick the candidate: locked master while stalled, else sole requester,
  // else the round-robin favourite.
  always_comb begin
    cand     = OWN_M0;
    cand_vld = 1'b0;
    if (state_q == ARB_HOLD) begin
      cand     = sel_q;
      cand_vld = (sel_q == OWN_M1) ? m1.req : m0.req;
    end else if (m0.req && m1.req) begin
      cand     = rr_q;
      cand_vld = 1'b1;
    end else if (m1.req) begin
      cand     = OWN_M1;
      cand_vld = 1'b1;
    end else if (m0.req) begin
      cand     = OWN_M0;
      cand_vld = 1'b1;
    end
  end

  // A full owner FIFO blocks new requests even if a response pops this
  // cycle, which keeps gnt free of any combinational path from rvalid.
  assign s_req = cand_vld && !fifo_full;
  assign push  = s_req && s.gnt;
  assign pop   = s.rvalid && !fifo_empty;

  // Slave-side request fields: mux of the candidate, zero when idle.
  always_comb begin
    mux_addr  = '0;
    mux_wdata = '0;
    s.we      = 1'b0;
    s.be      = '0;
    if (s_req) begin
      if (cand == OWN_M1) begin
        mux_addr  = m1.addr;
        mux_wdata = m1.wdata;
        s.we      = m1.we;
        s.be      = m1.be;
      end else begin
        mux_addr  = m0.addr;
        mux_wdata = m0.wdata;
        s.we      = m0.we;
        s.be      = m0.be;
      end
    end
  end

  assign s.req   = s_req;
  assign s.addr  = mux_addr;
  assign s.wdata = mux_wdata;

  // Grants pass straight through from the slave to the selected master.
  assign gnt0   = push && (cand == OWN_M0);
  assign gnt1   = push && (cand == OWN_M1);
  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  // Responses go to the FIFO head; the other master sees zero data.
  assign m0.rvalid = pop && (head == OWN_M0);
  assign m1.rvalid = pop && (head == OWN_M1);
  assign m0.rdata  = (pop && (head == OWN_M0)) ? s.rdata : '0;
  assign m1.rdata  = (pop && (head == OWN_M1)) ? s.rdata : '0;

  // Next-state logic: lock onto the candidate while the slave stalls.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ARB_IDLE: if (s_req && !s.gnt) begin
        state_d = ARB_HOLD;
        sel_d   = cand;
      end
      ARB_HOLD: if (s.gnt) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // FSM state and locked-master register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      sel_q   <= OWN_M0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Round-robin pointer: after each grant the other master is favoured.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rr_q <= OWN_M0;
    else if (push) rr_q <= other_owner(cand);
  end

  // Sticky error: a response arrived with nobody waiting for it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      err_o <= 1'b0;
    else if (s.rvalid && fifo_empty)  err_o <= 1'b1;
  end

  obi_arb_owner_fifo #(.DEPTH(MAX_OUTST)) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (cand),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef OBI_ARB_PERF_EN
  // Grant counts per master and conflict cycles; all wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_gnt0_o <= '0;
      cnt_gnt1_o <= '0;
      cnt_conf_o <= '0;
    end else begin
      if (gnt0) cnt_gnt0_o <= cnt_gnt0_o + PERF_CNT_W'(1);
      if (gnt1) cnt_gnt1_o <= cnt_gnt1_o + PERF_CNT_W'(1);
      if (state_q == ARB_IDLE && m0.req && m1.req && !fifo_full)
        cnt_conf_o <= cnt_conf_o + PERF_CNT_W'(1);
    end
  end
`else
  assign cnt_gnt0_o = '0;
  assign cnt_gnt1_o = '0;
  assign cnt_conf_o = '0;
`endif

endmodule

// File: tb/tb_obi_arbiter_2to1.sv
// Bench for obi_arbiter_2to1: directed scenarios followed by random traffic,
// all checked against a queue-based model of the arbitration rules.
module tb_obi_arbiter_2to1;
  import obi_arb_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_OUTST = 2;

  logic clk;
  logic rst_n;
  logic        err_o;
  logic [31:0] cnt_gnt0, cnt_gnt1, cnt_conf;

  obi_arbiter_2to1_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  obi_arbiter_2to1_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
  obi_arbiter_2to1_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

  obi_arbiter_2to1 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .m0         (m0_if),
    .m1         (m1_if),
    .s          (s_if),
    .err_o      (err_o),
    .cnt_gnt0_o (cnt_gnt0),
    .cnt_gnt1_o (cnt_gnt1),
    .cnt_conf_o (cnt_conf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: pending master requests, owner queue, lock, rr turn.
  bit          preq  [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata[2];
  logic [3:0]  pbe   [2];
  logic        pwe   [2];
  int          q[$];
  bit          lock;
  int          lock_own;
  int          turn;
  bit          err_m;
  int unsigned c0, c1, cc;

  // Last-cycle observations for directed expectations.
  logic        last_gnt[2];
  logic        last_rv [2];
  logic [31:0] last_rd [2];
  logic        last_sreq;
  logic [31:0] last_saddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    lock = 0; lock_own = 0; turn = 0; err_m = 0;
    c0 = 0; c1 = 0; cc = 0;
  endtask

  task automatic set_req(input int m, input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input logic [3:0] be);
    preq[m] = 1; paddr[m] = a; pwe[m] = we; pwdata[m] = wd; pbe[m] = be;
  endtask

  task automatic chk_regs();
    chk("err", err_o, err_m);
`ifdef OBI_ARB_PERF_EN
    chk("cnt_gnt0", cnt_gnt0, c0);
    chk("cnt_gnt1", cnt_gnt1, c1);
    chk("cnt_conf", cnt_conf, cc);
`else
    chk("cnt_gnt0", cnt_gnt0, 0);
    chk("cnt_gnt1", cnt_gnt1, 0);
    chk("cnt_conf", cnt_conf, 0);
`endif
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    preq[0] = 0; preq[1] = 0;
    m0_if.req = 0; m0_if.addr = '0; m0_if.we = 0; m0_if.be = '0; m0_if.wdata = '0;
    m1_if.req = 0; m1_if.addr = '0; m1_if.we = 0; m1_if.be = '0; m1_if.wdata = '0;
    s_if.gnt = 0; s_if.rvalid = 0; s_if.rdata = '0;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_s_req", s_if.req, 0);
    chk("rst_s_addr", s_if.addr, 0);
    chk("rst_m0_gnt", m0_if.gnt, 0);
    chk("rst_m1_gnt", m1_if.gnt, 0);
    chk("rst_m0_rvalid", m0_if.rvalid, 0);
    chk("rst_m1_rdata", m1_if.rdata, 0);
    chk_regs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle, starting and ending at a falling edge.
  task automatic cycle(input bit g, input bit rv, input logic [31:0] rd);
    int  c;
    bit  cv, full, esreq, pop;
    int  own;
    m0_if.req = preq[0]; m0_if.addr = paddr[0]; m0_if.we = pwe[0];
    m0_if.be  = pbe[0];  m0_if.wdata = pwdata[0];
    m1_if.req = preq[1]; m1_if.addr = paddr[1]; m1_if.we = pwe[1];
    m1_if.be  = pbe[1];  m1_if.wdata = pwdata[1];
    s_if.gnt = g; s_if.rvalid = rv; s_if.rdata = rd;
    #1;
    full = (q.size() >= MAX_OUTST);
    if (lock) begin
      c = lock_own; cv = preq[c];
    end else if (preq[0] && preq[1]) begin
      c = turn; cv = 1;
    end else begin
      c = preq[1] ? 1 : 0; cv = preq[0] | preq[1];
    end
    esreq = cv && !full;
    chk("s_req", s_if.req, esreq);
    chk("s_addr", s_if.addr, esreq ? paddr[c] : 32'h0);
    chk("s_we", s_if.we, esreq ? pwe[c] : 1'b0);
    chk("s_be", s_if.be, esreq ? pbe[c] : 4'h0);
    chk("s_wdata", s_if.wdata, esreq ? pwdata[c] : 32'h0);
    chk("m0_gnt", m0_if.gnt, esreq && g && c == 0);
    chk("m1_gnt", m1_if.gnt, esreq && g && c == 1);
    pop = rv && (q.size() > 0);
    own = pop ? q[0] : -1;
    chk("m0_rvalid", m0_if.rvalid, own == 0);
    chk("m1_rvalid", m1_if.rvalid, own == 1);
    chk("m0_rdata", m0_if.rdata, (own == 0) ? rd : 32'h0);
    chk("m1_rdata", m1_if.rdata, (own == 1) ? rd : 32'h0);
    last_gnt[0] = m0_if.gnt;  last_gnt[1] = m1_if.gnt;
    last_rv[0]  = m0_if.rvalid; last_rv[1] = m1_if.rvalid;
    last_rd[0]  = m0_if.rdata;  last_rd[1] = m1_if.rdata;
    last_sreq   = s_if.req;     last_saddr = s_if.addr;
    // Advance the model by the rules of this cycle.
    if (!lock && preq[0] && preq[1] && !full) cc++;
    if (rv) begin
      if (pop) void'(q.pop_front());
      else     err_m = 1;
    end
    if (esreq && g) begin
      q.push_back(c);
      if (c == 0) c0++; else c1++;
      turn = 1 - c;
      lock = 0;
      preq[c] = 0;
    end else if (esreq) begin
      lock = 1; lock_own = c;
    end else if (g) begin
      lock = 0;
    end
    @(negedge clk);
    chk_regs();
  endtask

  initial begin
    rst_n = 1'b0;
    paddr[0] = '0; paddr[1] = '0; pwdata[0] = '0; pwdata[1] = '0;
    pbe[0] = '0; pbe[1] = '0; pwe[0] = 0; pwe[1] = 0;
    do_reset();

    // Single M0 read, zero-latency grant, response one cycle later.
    set_req(0, 32'h100, 1'b0, 32'h0, 4'hF);
    cycle(1, 0, 32'h0);
    chk("t1_gnt0", last_gnt[0], 1);
    chk("t1_gnt1", last_gnt[1], 0);
    cycle(0, 1, 32'hDEADBEEF);
    chk("t1_rvalid0", last_rv[0], 1);
    chk("t1_rdata0", last_rd[0], 32'hDEADBEEF);
    chk("t1_rvalid1", last_rv[1], 0);

    // Both masters always requesting: grants alternate starting with M0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!preq[0]) set_req(0, 32'h1000 + i, 1'b1, $urandom, 4'h3);
      if (!preq[1]) set_req(1, 32'h2000 + i, 1'b0, $urandom, 4'hC);
      cycle(1, q.size() > 0, $urandom);
      chk("alt_gnt0", last_gnt[0], (i % 2) == 0);
      chk("alt_gnt1", last_gnt[1], (i % 2) == 1);
    end
`ifdef OBI_ARB_PERF_EN
    chk("alt_conf", cnt_conf, 4);
`else
    chk("alt_conf", cnt_conf, 0);
`endif
    preq[0] = 0; preq[1] = 0;
    cycle(0, 1, 32'h5);

    // Slave stalls M1; a late M0 request must not steal the bus.
    do_reset();
    set_req(1, 32'hB000, 1'b0, 32'h0, 4'hF);
    cycle(0, 0, 0);
    set_req(0, 32'hA000, 1'b1, 32'h1234, 4'h1);
    cycle(0, 0, 0);
    chk("hold_addr1", last_saddr, 32'hB000);
    cycle(0, 0, 0);
    chk("hold_addr2", last_saddr, 32'hB000);
    cycle(1, 0, 0);
    chk("hold_gnt1", last_gnt[1], 1);
    cycle(1, 0, 0);
    chk("hold_gnt0", last_gnt[0], 1);
    cycle(0, 1, 32'h11);
    cycle(0, 1, 32'h22);

    // Owner FIFO full: third request blocked, reissued after a response.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (!preq[0]) set_req(0, 32'h300 + i, 1'b0, 0, 4'hF);
      cycle(1, 0, 0);
    end
    chk("full_sreq", last_sreq, 0);
    cycle(1, 1, 32'h77);
    chk("full_sreq_pop", last_sreq, 0);
    cycle(1, 0, 0);
    chk("full_reissue", last_gnt[0], 1);
    cycle(0, 1, 1);
    cycle(0, 1, 2);

    // Interleaved owners: responses in order go to M0 then M1.
    do_reset();
    set_req(0, 32'h40, 1'b0, 0, 4'hF);
    set_req(1, 32'h80, 1'b0, 0, 4'hF);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 1, 32'hA);
    chk("ord_rd0", last_rd[0], 32'hA);
    cycle(0, 1, 32'hB);
    chk("ord_rd1", last_rd[1], 32'hB);

    // Stray response with nothing outstanding: dropped and flagged.
    cycle(0, 1, 32'hC);
    chk("stray_rv0", last_rv[0], 0);
    chk("stray_rv1", last_rv[1], 0);
    chk("stray_err", err_o, 1);
    cycle(0, 0, 0);
    chk("stray_sticky", err_o, 1);

    // Reset in the middle of a stalled, outstanding transaction.
    set_req(0, 32'h500, 1'b0, 0, 4'hF);
    cycle(1, 0, 0);
    set_req(1, 32'h600, 1'b1, 32'h9, 4'hF);
    cycle(0, 0, 0);
    do_reset();
    cycle(0, 1, 32'hEE);
    chk("late_rv_err", err_o, 1);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++)
        if (!preq[m] && $urandom_range(0, 99) < 60)
          set_req(m, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
      cycle($urandom_range(0, 99) < 65,
            (q.size() > 0) && ($urandom_range(0, 99) < 50),
            $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
